// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - multi-byte 8N1 UART frame transmitter
//
// Purpose: on start, latches NUM_BYTES bytes from data_flat and sends them
// back-to-back over tx, LSB first, byte 0 first. Every bit (start, data,
// stop) lasts CLKS_PER_BIT cycles.
//
// Optional feature: define UART_FRAME_CHECKSUM_EN to append one extra byte
// equal to the XOR of all latched payload bytes.
//
// Ports:
//   clk_100MHz  in   system clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   start       in   frame request, honoured only while busy=0
//   data_flat   in   payload, byte i = data_flat[i*8 +: 8]
//   tx          out  UART serial line, idle high
//   busy        out  high from accept edge until the frame completes
//   byte_sent   out  1-cycle pulse as each byte's stop bit completes
//   done        out  1-cycle pulse as the final stop bit completes

module uart_frame_tx #(
  parameter int NUM_BYTES    = 10,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_BYTES*8-1:0] data_flat,
  output logic                   tx,
  output logic                   busy,
  output logic                   byte_sent,
  output logic                   done
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
  localparam int TOTAL_BYTES = NUM_BYTES;
`endif

  localparam int IW = $clog2(NUM_BYTES + 2);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL_BYTES - 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          baud_cnt, baud_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [IW-1:0]          byte_idx, byte_idx_n;
  logic [NUM_BYTES*8-1:0] frame_reg, frame_n;
  logic [7:0]             shift_reg, shift_n;
  logic                   tx_n, busy_n, byte_sent_n, done_n;
  logic                   bit_end;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [IW-1:0] PAYLOAD_LAST = IW'(NUM_BYTES - 1);
  logic [7:0] csum_reg, csum_n;
  logic [7:0] data_xor;

  always_comb begin
    data_xor = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      data_xor = data_xor ^ data_flat[i*8 +: 8];
    end
  end
`endif

  assign bit_end = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      frame_reg <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      byte_sent <= 1'b0;
      done      <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_cnt_n;
      byte_idx  <= byte_idx_n;
      frame_reg <= frame_n;
      shift_reg <= shift_n;
      tx        <= tx_n;
      busy      <= busy_n;
      byte_sent <= byte_sent_n;
      done      <= done_n;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_reg  <= csum_n;
`endif
    end
  end

  // frame_reg holds the bytes still to be sent; it shifts down one byte each
  // time the next byte moves into shift_reg, so byte_idx is only a counter.
  always_comb begin
    state_n     = state;
    baud_n      = baud_cnt;
    bit_cnt_n   = bit_cnt;
    byte_idx_n  = byte_idx;
    frame_n     = frame_reg;
    shift_n     = shift_reg;
    tx_n        = tx;
    busy_n      = busy;
    byte_sent_n = 1'b0;
    done_n      = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_n      = csum_reg;
`endif

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        if (start) begin
          frame_n    = data_flat >> 8;
          shift_n    = data_flat[7:0];
          byte_idx_n = '0;
          bit_cnt_n  = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          state_n    = START_BIT;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_n     = data_xor;
`endif
        end
      end

      START_BIT: begin
        if (bit_end) begin
          baud_n  = '0;
          tx_n    = shift_reg[0];
          state_n = DATA_BITS;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            tx_n      = 1'b1;
            state_n   = STOP_BIT;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shift_reg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          baud_n      = '0;
          byte_sent_n = 1'b1;
          if (byte_idx == LAST_IDX) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
            state_n = IDLE;
          end else begin
            byte_idx_n = byte_idx + 1'b1;
            frame_n    = frame_reg >> 8;
            shift_n    = frame_reg[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
            if (byte_idx == PAYLOAD_LAST) begin
              shift_n = csum_reg;
            end
`endif
            tx_n    = 1'b0;
            state_n = START_BIT;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
